// File: rtl/pinmux_pkg.sv
// pinmux_pkg: drive-mode, irq-mode and pin FSM encodings shared by pin slices and the register block
package pinmux_pkg;
   localparam logic [1:0] DRV_PP    = 2'b00;
   localparam logic [1:0] DRV_OS    = 2'b01;
   localparam logic [1:0] DRV_OD    = 2'b10;
   localparam logic [1:0] DRV_OFF   = 2'b11;
   localparam logic [1:0] IRQ_OFF   = 2'b00;
   localparam logic [1:0] IRQ_RISE  = 2'b01;
   localparam logic [1:0] IRQ_FALL  = 2'b10;
   localparam logic [1:0] IRQ_BOTH  = 2'b11;
   localparam logic [1:0] ST_RUN    = 2'd0;
   localparam logic [1:0] ST_DRAIN  = 2'd1;
   localparam logic [1:0] ST_SWITCH = 2'd2;
   function automatic logic irq_hit(input logic [1:0] mode, input logic rise, input logic fall);
      return (rise && (mode == IRQ_RISE || mode == IRQ_BOTH)) ||
             (fall && (mode == IRQ_FALL || mode == IRQ_BOTH));
   endfunction
endpackage

// File: rtl/pinmux_in_filter.sv
// pinmux_in_filter: pad input synchroniser, length-L glitch filter and edge detect
module pinmux_in_filter #(
   parameter int FILT_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              pad_y,
   input  logic [FILT_W-1:0] len,
   output logic              filt,
   output logic              rise,
   output logic              fall
);
   logic s1, s2, filt_d;
   logic [FILT_W-1:0] cnt, lim;
   assign lim  = (len == '0) ? '0 : len - 1'b1;
   assign rise = filt & ~filt_d;
   assign fall = ~filt & filt_d;
   // sync the pad, accept a new level only after it has been stable for max(len,1) cycles
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1     <= 1'b0;
         s2     <= 1'b0;
         filt   <= 1'b0;
         filt_d <= 1'b0;
         cnt    <= '0;
      end else begin
         s1     <= pad_y;
         s2     <= s1;
         filt_d <= filt;
         if (s2 != filt) begin
            if (cnt == lim) begin
               filt <= s2;
               cnt  <= '0;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end else begin
            cnt <= '0;
         end
      end
   end
endmodule

// File: rtl/pinmux_pin_ctrl.sv
// pinmux_pin_ctrl: per-pin function select with glitch-free switching, pad control registers and input/irq routing
module pinmux_pin_ctrl import pinmux_pkg::*; #(
   parameter int NFUNC  = 4,
   parameter int FILT_W = 4,
   parameter int GAP    = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [$clog2(NFUNC)-1:0] cfg_sel,
   input  logic [1:0]               cfg_mode,
   input  logic                     cfg_pu,
   input  logic                     cfg_pd,
   input  logic                     cfg_ie,
   input  logic                     cfg_cs,
   input  logic                     cfg_dr,
   input  logic                     cfg_sr,
   input  logic [FILT_W-1:0]        cfg_filt_len,
   input  logic [1:0]               cfg_irq_mode,
   input  logic [NFUNC-1:0]         func_out,
   input  logic [NFUNC-1:0]         func_oe,
   output logic [NFUNC-1:0]         func_in,
   input  logic                     irq_clr,
   output logic                     irq,
   output logic                     sel_busy,
   output logic                     pad_a,
   output logic                     pad_oe,
   output logic                     pad_od,
   output logic                     pad_os,
   output logic                     pad_pu,
   output logic                     pad_pd,
   output logic                     pad_ie,
   output logic                     pad_cs,
   output logic                     pad_dr,
   output logic                     pad_sr,
   input  logic                     pad_y
);
   localparam int SW = $clog2(NFUNC);
   localparam int GW = $clog2(GAP + 1);
   logic [1:0]    state;
   logic [GW-1:0] gcnt;
   logic [SW-1:0] active_sel;
   logic          run, sel_change, filt, rise, fall;
   assign run        = state == ST_RUN;
   assign sel_change = cfg_sel != active_sel;
   pinmux_in_filter #(.FILT_W(FILT_W)) u_filt (
      .clk   (clk),
      .rst_n (rst_n),
      .pad_y (pad_y),
      .len   (cfg_filt_len),
      .filt  (filt),
      .rise  (rise),
      .fall  (fall)
   );
   // owner switch: drain the pad for GAP cycles, then adopt the latest requested owner
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_RUN;
         gcnt       <= '0;
         active_sel <= '0;
         sel_busy   <= 1'b0;
      end else begin
         sel_busy <= !run || sel_change;
         if (run) begin
            if (sel_change) begin
               state <= ST_DRAIN;
               gcnt  <= GW'(GAP - 1);
            end
         end else if (state == ST_DRAIN) begin
            if (gcnt == '0) state <= ST_SWITCH;
            else gcnt <= gcnt - 1'b1;
         end else begin
            state      <= ST_RUN;
            active_sel <= cfg_sel;
         end
      end
   end
   // pad controls: data/enable only from the owner while running, electrical config always follows cfg
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pad_a            <= 1'b0;
         pad_oe           <= 1'b0;
         {pad_od, pad_os} <= DRV_OFF;
         {pad_pu, pad_pd, pad_ie, pad_cs, pad_dr, pad_sr} <= '0;
      end else begin
         pad_a            <= run & func_out[active_sel];
         pad_oe           <= run & func_oe[active_sel];
         {pad_od, pad_os} <= cfg_mode;
         {pad_pu, pad_pd, pad_ie, pad_cs, pad_dr, pad_sr} <= {cfg_pu, cfg_pd, cfg_ie, cfg_cs, cfg_dr, cfg_sr};
      end
   end
   // route the filtered input to the owner only, and keep a sticky edge interrupt where set beats clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         func_in <= '0;
         irq     <= 1'b0;
      end else begin
         func_in <= run ? (NFUNC'(filt & cfg_ie) << active_sel) : '0;
         irq     <= irq_hit(cfg_irq_mode, rise, fall) ? 1'b1 : irq_clr ? 1'b0 : irq;
      end
   end
endmodule

// File: tb/tb_pinmux_pin_ctrl.sv
// tb_pinmux_pin_ctrl: table vectors plus scoreboard-timed sequences for switching, filtering, irq and reset
module tb_pinmux_pin_ctrl;
   localparam int NFUNC = 4;
   localparam int FILT_W = 4;
   localparam int GAP = 2;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [1:0] cfg_sel = '0;
   logic [1:0] cfg_mode = '0;
   logic cfg_pu = 0, cfg_pd = 0, cfg_ie = 0, cfg_cs = 0, cfg_dr = 0, cfg_sr = 0;
   logic [FILT_W-1:0] cfg_filt_len = 4'd4;
   logic [1:0] cfg_irq_mode = 2'b01;
   logic [NFUNC-1:0] func_out = 4'hF, func_oe = 4'hF, func_in;
   logic irq_clr = 1'b0, irq, sel_busy, pad_y = 1'b0;
   logic pad_a, pad_oe, pad_od, pad_os, pad_pu, pad_pd, pad_ie, pad_cs, pad_dr, pad_sr;
   logic [15:0] obs;
   pinmux_pin_ctrl #(.NFUNC(NFUNC), .FILT_W(FILT_W), .GAP(GAP)) dut (
      .clk(clk), .rst_n(rst_n), .cfg_sel(cfg_sel), .cfg_mode(cfg_mode),
      .cfg_pu(cfg_pu), .cfg_pd(cfg_pd), .cfg_ie(cfg_ie), .cfg_cs(cfg_cs), .cfg_dr(cfg_dr), .cfg_sr(cfg_sr),
      .cfg_filt_len(cfg_filt_len), .cfg_irq_mode(cfg_irq_mode), .func_out(func_out), .func_oe(func_oe),
      .func_in(func_in), .irq_clr(irq_clr), .irq(irq), .sel_busy(sel_busy),
      .pad_a(pad_a), .pad_oe(pad_oe), .pad_od(pad_od), .pad_os(pad_os), .pad_pu(pad_pu), .pad_pd(pad_pd),
      .pad_ie(pad_ie), .pad_cs(pad_cs), .pad_dr(pad_dr), .pad_sr(pad_sr), .pad_y(pad_y)
   );
   always #5 clk = ~clk;
   assign obs = {sel_busy, irq, func_in, pad_a, pad_oe, pad_od, pad_os, pad_pu, pad_pd, pad_ie, pad_cs, pad_dr, pad_sr};
   typedef struct {
      string       name;
      int          at;
      logic [15:0] exp;
      logic [15:0] mask;
   } exp_t;
   typedef struct {
      logic [1:0]  mode;
      logic [5:0]  cfg;
      logic [3:0]  fout;
      logic [3:0]  foe;
      logic [15:0] exp;
   } vec_t;
   exp_t sb[$];
   exp_t cur;
   vec_t vt[6];
   int errors = 0, checks = 0, cyc = 0;
   task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp, input logic [15:0] mask);
      checks++;
      if ((got & mask) !== (exp & mask)) begin
         errors++;
         $display("FAIL %s: got %h expected %h (mask %h) cycle %0d", name, got & mask, exp & mask, mask, cyc);
      end
   endtask
   task automatic expect_at(input string name, input int dly, input logic [15:0] exp, input logic [15:0] mask);
      exp_t e;
      int i;
      e.name = name;
      e.at = cyc + dly;
      e.exp = exp;
      e.mask = mask;
      i = 0;
      while (i < sb.size() && sb[i].at <= e.at) i++;
      sb.insert(i, e);
   endtask
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask
   always @(posedge clk) begin
      cyc++;
      #1;
      while (sb.size() > 0 && sb[0].at <= cyc) begin
         cur = sb.pop_front();
         check(cur.name, obs, cur.exp, cur.mask);
      end
   end
   initial begin
      vt[0] = '{2'b00, 6'b000000, 4'b0001, 4'b0001, 16'h0300};
      vt[1] = '{2'b01, 6'b100000, 4'b0000, 4'b0001, 16'h0160};
      vt[2] = '{2'b10, 6'b010000, 4'b0001, 4'b0000, 16'h0290};
      vt[3] = '{2'b11, 6'b001100, 4'b1110, 4'b1110, 16'h00CC};
      vt[4] = '{2'b00, 6'b000011, 4'b1111, 4'b1110, 16'h0203};
      vt[5] = '{2'b00, 6'b111111, 4'b0000, 4'b1111, 16'h013F};
      // reset hold then release with all functions driving 1
      tick(1);
      expect_at("rst_hold", 1, 16'h00C0, 16'hFFFF);
      tick(2);
      rst_n = 1'b1;
      expect_at("first_run", 1, 16'h0300, 16'hFFFF);
      tick(1);
      // table vectors with owner 0
      for (int i = 0; i < 6; i++) begin
         cfg_mode = vt[i].mode;
         {cfg_pu, cfg_pd, cfg_ie, cfg_cs, cfg_dr, cfg_sr} = vt[i].cfg;
         func_out = vt[i].fout;
         func_oe = vt[i].foe;
         expect_at($sformatf("vec%0d", i), 1, vt[i].exp, 16'hFFFF);
         tick(1);
      end
      // switch 0 -> 2
      {cfg_pu, cfg_pd, cfg_ie, cfg_cs, cfg_dr, cfg_sr} = '0;
      func_out = 4'b0001;
      func_oe = 4'b0101;
      tick(1);
      cfg_sel = 2'd2;
      expect_at("sw_k1", 1, 16'h8300, 16'h8300);
      expect_at("sw_k2", 2, 16'h8000, 16'h8300);
      expect_at("sw_k3", 3, 16'h8000, 16'h8300);
      expect_at("sw_k4", 4, 16'h8000, 16'h8300);
      expect_at("sw_k5", 5, 16'h0100, 16'h8300);
      tick(6);
      // request changes mid-drain: latest wins
      func_out = 4'b1001;
      func_oe = 4'b1101;
      cfg_sel = 2'd1;
      expect_at("late_k1", 1, 16'h8100, 16'h8300);
      expect_at("late_k2", 2, 16'h8000, 16'h8300);
      expect_at("late_k5", 5, 16'h0300, 16'h8300);
      tick(1);
      cfg_sel = 2'd3;
      tick(5);
      // request returns to current owner mid-drain: switch still completes
      cfg_sel = 2'd0;
      expect_at("ret_k2", 2, 16'h8000, 16'h8300);
      expect_at("ret_k4", 4, 16'h8000, 16'h8300);
      expect_at("ret_k5", 5, 16'h0300, 16'h8300);
      tick(1);
      cfg_sel = 2'd3;
      tick(5);
      // 3-cycle glitch is suppressed with L=4
      cfg_ie = 1'b1;
      tick(1);
      pad_y = 1'b1;
      expect_at("glitch_k7", 7, 16'h0000, 16'h7C00);
      expect_at("glitch_k9", 9, 16'h0000, 16'h7C00);
      tick(3);
      pad_y = 1'b0;
      tick(10);
      // 4-cycle pulse passes, irq sticky across the falling edge
      pad_y = 1'b1;
      expect_at("pulse_k6", 6, 16'h0000, 16'h7C00);
      expect_at("pulse_k7", 7, 16'h6000, 16'h7C00);
      expect_at("pulse_k10", 10, 16'h6000, 16'h7C00);
      expect_at("pulse_k11", 11, 16'h4000, 16'h7C00);
      tick(4);
      pad_y = 1'b0;
      tick(10);
      // clear alone drops irq
      irq_clr = 1'b1;
      expect_at("clr_only", 1, 16'h0000, 16'h4000);
      tick(1);
      irq_clr = 1'b0;
      tick(1);
      // clear coincident with a new rise: set wins
      pad_y = 1'b1;
      expect_at("setclr_k7", 7, 16'h6000, 16'h7C00);
      expect_at("setclr_k8", 8, 16'h6000, 16'h7C00);
      tick(6);
      irq_clr = 1'b1;
      tick(1);
      irq_clr = 1'b0;
      tick(2);
      // open-drain reporting, input disabled, irq mode off
      cfg_mode = 2'b10;
      cfg_ie = 1'b0;
      cfg_irq_mode = 2'b00;
      irq_clr = 1'b1;
      expect_at("od_k1", 1, 16'h0380, 16'hFFFF);
      expect_at("od_k9", 9, 16'h0380, 16'hFFFF);
      expect_at("od_k18", 18, 16'h0380, 16'hFFFF);
      tick(1);
      irq_clr = 1'b0;
      pad_y = 1'b0;
      tick(8);
      pad_y = 1'b1;
      tick(10);
      // reset asserted during drain
      cfg_mode = 2'b00;
      cfg_ie = 1'b1;
      cfg_irq_mode = 2'b01;
      pad_y = 1'b0;
      func_out = 4'b0001;
      func_oe = 4'b0001;
      tick(8);
      cfg_sel = 2'd1;
      expect_at("pre_rst_busy", 2, 16'h8000, 16'h8100);
      tick(2);
      rst_n = 1'b0;
      #1;
      check("rst_async", obs, 16'h00C0, 16'hFFFF);
      cfg_sel = 2'd0;
      tick(1);
      expect_at("rst_hold2", 1, 16'h00C0, 16'hFFFF);
      tick(1);
      rst_n = 1'b1;
      expect_at("post_rst", 1, 16'h0308, 16'hFFFF);
      tick(3);
      if (sb.size() != 0) begin
         errors++;
         checks++;
         $display("FAIL sb_pending: got %0d entries left expected 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/pinmux_pin_ctrl.md
# pinmux_pin_ctrl

Per-pin control slice that sits directly upstream of one bidirectional mux pad cell. It selects which of NFUNC peripheral functions owns the pin, drives the pad's data, output-enable, drive-mode, pull and input-enable controls from registered state, and performs glitch-free function switching. It also synchronises and filters the pad input, routes it back to the owning function, and raises a sticky edge interrupt.

## Interface
- NFUNC, 4: number of selectable peripheral functions (2..8)
- FILT_W, 4: glitch-filter length width
- GAP, 2: cycles pad output is forced off during a function switch (≥1)
- clk  in  1  sole clock
- rst_n  in  1  asynchronous active-low reset
- cfg_sel  in  $clog2(NFUNC)  requested owning function
- cfg_mode  in  2  drive mode: 00 push-pull, 01 open-source (drive only A=1), 10 open-drain (drive only A=0), 11 output disabled
- cfg_pu, cfg_pd, cfg_ie, cfg_cs, cfg_dr, cfg_sr  in  1 each  pull-up, pull-down, input enable, schmitt, drive strength, slew
- cfg_filt_len  in  FILT_W  filter length L in cycles
- cfg_irq_mode  in  2  00 off, 01 rise, 10 fall, 11 both
- func_out, func_oe  in  NFUNC each  per-function output data / enable
- func_in  out  NFUNC  filtered pad input, only owning bit active
- irq_clr  in  1  pulse, clears pending interrupt
- irq  out  1  sticky pending interrupt
- sel_busy  out  1  high while a function switch is in progress
- pad_a, pad_oe, pad_od, pad_os, pad_pu, pad_pd, pad_ie, pad_cs, pad_dr, pad_sr  out  1 each  pad controls
- pad_y  in  1  pad input (asynchronous)

## Operation
- Reset values: pad_a 0, pad_oe 0, pad_od 1, pad_os 1 (mode 11), pad_pu/pd/ie/cs/dr/sr 0, func_in 0, irq 0, sel_busy 0, active_sel 0, FSM RUN, filter state 0, counter 0.
- FSM RUN: pad_a/pad_oe <= func_out/func_oe[active_sel]; {pad_od,pad_os} <= cfg_mode; other pad controls <= cfg_*. If cfg_sel != active_sel → DRAIN, gap counter = GAP-1.
- DRAIN: pad_oe <= 0, pad_a <= 0, func_in all 0, sel_busy 1; pulls/ie/mode keep following cfg. Counter decrements; at 0 → SWITCH.
- SWITCH (1 cycle): active_sel <= cfg_sel (value sampled this cycle), sel_busy 1 → RUN. If cfg_sel changed during DRAIN, the latest value wins; if it returned to the old value, switch still completes (no abort).
- Input path: 2-flop synchroniser s2; filter: if s2 != filt, cnt++ and when cnt == max(L,1)-1 filt <= s2, cnt <= 0; if s2 == filt, cnt <= 0. L=0 behaves as L=1. Pulses shorter than max(L,1) cycles after sync are suppressed.
- func_in[active_sel] = filt & cfg_ie (registered), others 0; all 0 outside RUN.
- Edge detect on filt vs filt_d: matching edge per cfg_irq_mode sets pending. irq_clr clears; set and clear same cycle → set wins. cfg_irq_mode=00 blocks new sets, does not clear.
- cfg changes other than cfg_sel take effect on pad the next cycle; no gating.

## Timing
- func_out/func_oe → pad_a/pad_oe: 1 cycle.
- cfg_sel change → sel_busy high next cycle; new owner drives pad GAP+2 cycles after the change; pad_oe low for GAP+1 cycles between owners.
- pad_y edge → filt: 2 (sync) + max(L,1) cycles; → func_in: +1; → irq: +1 after filt (same as func_in).
- Reset asserted mid-switch or mid-filter: all state returns to reset values immediately; no pad drive until first RUN cycle after release.

## Structure
- pinmux_pkg: drive-mode encodings, irq-mode encodings, FSM state enum (RUN, DRAIN, SWITCH); shared by all pin slices and the pinmux register block.
- Sub-module pinmux_in_filter: synchroniser + glitch filter + edge detect, outputs filt, rise, fall.
- Top pinmux_pin_ctrl: FSM, output muxing/registers, input routing, irq pending.

## Test plan
- Reset release with func_oe=1111, func_out=1111 → pad_oe=0, pad_od=pad_os=1 until first RUN cycle; then pad_oe=1, pad_a=1 one cycle later.
- cfg_sel 0→2 with GAP=2, func0 oe=1, func2 oe=1 out=0 → sel_busy high 4 cycles, pad_oe 0 for exactly 3 cycles, then pad_a=0 driven from func2.
- L=4: pad_y high pulse of 3 cycles → no filt change, irq 0; pulse of 4 cycles → func_in[active_sel] rises 7 cycles after pad_y edge.
- cfg_irq_mode=01, rising edge → irq=1; falling edge → irq stays 1; irq_clr same cycle as new rise → irq remains 1.
- cfg_mode=10, pad_a path driven 1 → pad_od=1, pad_os=0 reported; cfg_ie=0 → func_in stays 0 regardless of pad_y.
- rst_n asserted during DRAIN → pad outputs, sel_busy, irq at reset values immediately; active_sel=0 after release.
